// File: rtl/signed_lteq_threshold_filter.sv
// Streaming signed <= threshold filter with a 2-entry output FIFO.
// Optional statistics counters are built when LTEQ_FILT_STATS_EN is defined.
module signed_lteq_threshold_filter #(
  parameter int unsigned DW     = 32,
  parameter int unsigned CNT_W  = 16,
  parameter bit          INVERT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          thr_load,
  input  logic [DW-1:0] thr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          armed
`ifdef LTEQ_FILT_STATS_EN
  ,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] thr_q;
  logic [DW-1:0] mem_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          accept, le, pass, push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (thr_load) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // in_ready depends on registers only, so a same-cycle pop cannot reopen it.
  assign armed     = (state_q == StRun);
  assign in_ready  = armed && (count_q < 2'd2);
  assign accept    = in_valid && in_ready;
  assign le        = $signed(in_data) <= $signed(thr_q);
  assign pass      = INVERT ? ~le : le;
  assign push      = accept && pass;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      thr_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      // A sample accepted alongside thr_load still sees the old threshold.
      if (thr_load) thr_q <= thr_data;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef LTEQ_FILT_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] pass_cnt_q, drop_cnt_q;

  // Clear wins over a same-cycle increment; counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst || thr_load) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + CntOne;
      if (accept && !pass && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CntOne;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_signed_lteq_threshold_filter.sv
// Bench for signed_lteq_threshold_filter: INVERT=0 and INVERT=1 instances share stimulus
// and are checked against a queue-based reference model.
module tb_signed_lteq_threshold_filter;

  localparam int CntMax = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        thr_load = 1'b0;
  logic [31:0] thr_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready0, out_valid0, armed0, in_ready1, out_valid1, armed1;
  logic [31:0] out_data0, out_data1;
`ifdef LTEQ_FILT_STATS_EN
  logic [3:0]  pass_cnt0, drop_cnt0, pass_cnt1, drop_cnt1;
`endif

  always #5 clk = ~clk;

  signed_lteq_threshold_filter #(.DW(32), .CNT_W(4), .INVERT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .thr_load(thr_load), .thr_data(thr_data),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .armed(armed0)
`ifdef LTEQ_FILT_STATS_EN
    , .pass_cnt(pass_cnt0), .drop_cnt(drop_cnt0)
`endif
  );

  signed_lteq_threshold_filter #(.DW(32), .CNT_W(4), .INVERT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .thr_load(thr_load), .thr_data(thr_data),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .armed(armed1)
`ifdef LTEQ_FILT_STATS_EN
    , .pass_cnt(pass_cnt1), .drop_cnt(drop_cnt1)
`endif
  );

  // Reference model state
  bit          m_armed;
  logic [31:0] m_thr;
  logic [31:0] q0[$], q1[$], got0[$], got1[$];
  int          p0, d0, p1, d1;
  int          n_checks, n_fail;
  logic [5:0]  exp_flags, obs_flags;

  task automatic drive(input bit iv, input logic [31:0] id, input bit tl,
                       input logic [31:0] td, input bit ordy);
    in_valid = iv; in_data = id; thr_load = tl; thr_data = td; out_ready = ordy;
  endtask

  // Advance one clock and update the model from the inputs presented this cycle.
  task automatic tick();
    bit rdy0, rdy1, le;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete();
      m_armed = 1'b0; m_thr = '0;
      p0 = 0; d0 = 0; p1 = 0; d1 = 0;
    end else begin
      rdy0 = m_armed && (q0.size() < 2);
      rdy1 = m_armed && (q1.size() < 2);
      le   = $signed(in_data) <= $signed(m_thr);
      if (out_ready && q0.size() > 0) void'(q0.pop_front());
      if (out_ready && q1.size() > 0) void'(q1.pop_front());
      if (in_valid && rdy0 && le) q0.push_back(in_data);
      if (in_valid && rdy1 && !le) q1.push_back(in_data);
      if (thr_load) begin
        p0 = 0; d0 = 0; p1 = 0; d1 = 0;
      end else begin
        if (in_valid && rdy0) begin
          if (le) p0 = (p0 < CntMax) ? p0 + 1 : CntMax;
          else    d0 = (d0 < CntMax) ? d0 + 1 : CntMax;
        end
        if (in_valid && rdy1) begin
          if (!le) p1 = (p1 < CntMax) ? p1 + 1 : CntMax;
          else     d1 = (d1 < CntMax) ? d1 + 1 : CntMax;
        end
      end
      if (thr_load) begin
        m_thr   = thr_data;
        m_armed = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h5, 1'b0, '0, 1'b1);
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({armed0, in_ready0, out_valid0, armed1, in_ready1, out_valid1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {armed0, in_ready0, out_valid0, armed1, in_ready1, out_valid1});
    end
    n_checks++;
    if (out_data0 !== 32'h0 || out_data1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h/%h want 0/0", out_data0, out_data1);
    end
    rst = 1'b0;
    tick();
  endtask

  // thr=0 then thr=0x80000000 on both polarities.
  task automatic test_compare();
    logic [31:0] stim [8];
    bit          tl   [8];
    stim = '{32'h5, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0001,
             32'h7FFF_FFFF};
    tl   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    got0.delete(); got1.delete();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(1'b1, stim[c], tl[c], (c == 0) ? 32'h0 : 32'h8000_0000, 1'b1);
      else drive(1'b0, '0, 1'b0, '0, 1'b1);
      if (c == 4) in_valid = 1'b0;
      @(negedge clk);
      exp_flags = {m_armed, m_armed && q0.size() < 2, q0.size() > 0,
                   m_armed, m_armed && q1.size() < 2, q1.size() > 0};
      obs_flags = {armed0, in_ready0, out_valid0, armed1, in_ready1, out_valid1};
      n_checks++;
      if (obs_flags !== exp_flags) begin
        n_fail++; $display("FAIL compare_flags c=%0d: got %b want %b", c, obs_flags, exp_flags);
      end
      if (q0.size() > 0) begin
        n_checks++;
        if (out_data0 !== q0[0]) begin
          n_fail++; $display("FAIL compare_data0 c=%0d: got %h want %h", c, out_data0, q0[0]);
        end
      end
      if (q1.size() > 0) begin
        n_checks++;
        if (out_data1 !== q1[0]) begin
          n_fail++; $display("FAIL compare_data1 c=%0d: got %h want %h", c, out_data1, q1[0]);
        end
      end
      if (out_valid0 && out_ready) got0.push_back(out_data0);
      if (out_valid1 && out_ready) got1.push_back(out_data1);
      tick();
    end
    n_checks++;
    if (got0.size() != 3 || got0[0] !== 32'hFFFF_FFFF || got0[1] !== 32'h0 ||
        got0[2] !== 32'h8000_0000) begin
      n_fail++; $display("FAIL compare_seq0: got %p want FFFFFFFF,0,80000000", got0);
    end
    n_checks++;
    if (got1.size() != 3 || got1[0] !== 32'h1 || got1[1] !== 32'h8000_0001 ||
        got1[2] !== 32'h7FFF_FFFF) begin
      n_fail++; $display("FAIL compare_seq1: got %p want 1,80000001,7FFFFFFF", got1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s [3];
    int idx;
    bit acc;
    s = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    idx = 0;
    drive(1'b0, '0, 1'b1, 32'h7FFF_FFFF, 1'b0);
    tick();
    got0.delete(); got1.delete();
    for (int c = 0; c < 16; c++) begin
      drive(idx < 3, (idx < 3) ? s[idx] : 32'h0, 1'b0, '0, c >= 5);
      @(negedge clk);
      exp_flags = {m_armed, m_armed && q0.size() < 2, q0.size() > 0,
                   m_armed, m_armed && q1.size() < 2, q1.size() > 0};
      obs_flags = {armed0, in_ready0, out_valid0, armed1, in_ready1, out_valid1};
      n_checks++;
      if (obs_flags !== exp_flags) begin
        n_fail++; $display("FAIL bp_flags c=%0d: got %b want %b", c, obs_flags, exp_flags);
      end
      if (q0.size() > 0) begin
        n_checks++;
        if (out_data0 !== q0[0]) begin
          n_fail++; $display("FAIL bp_data0 c=%0d: got %h want %h", c, out_data0, q0[0]);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (in_ready0 !== 1'b0 || out_data0 !== s[0]) begin
          n_fail++;
          $display("FAIL bp_full: got in_ready=%b head=%h want 0 %h", in_ready0, out_data0, s[0]);
        end
      end
      if (out_valid0 && out_ready) got0.push_back(out_data0);
      acc = in_valid && m_armed && (q0.size() < 2);
      tick();
      if (acc) idx++;
    end
    n_checks++;
    if (got0.size() != 3 || got0[0] !== s[0] || got0[1] !== s[1] || got0[2] !== s[2]) begin
      n_fail++; $display("FAIL bp_order: got %p want A,B,C", got0);
    end
  endtask

  task automatic test_thr_change();
    drive(1'b0, '0, 1'b1, 32'd10, 1'b1);
    tick();
    got0.delete(); got1.delete();
    for (int c = 0; c < 6; c++) begin
      drive(c < 2, 32'd5, c == 0, 32'd3, 1'b1);
      @(negedge clk);
      if (out_valid0 && out_ready) got0.push_back(out_data0);
      if (out_valid1 && out_ready) got1.push_back(out_data1);
      tick();
    end
    n_checks++;
    if (got0.size() != 1 || got0[0] !== 32'd5) begin
      n_fail++; $display("FAIL thr_change0: got %p want 5", got0);
    end
    n_checks++;
    if (got1.size() != 1 || got1[0] !== 32'd5) begin
      n_fail++; $display("FAIL thr_change1: got %p want 5", got1);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b1, 32'h7FFF_FFFF, 1'b0);
    tick();
    drive(1'b1, 32'h1111, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 32'h2222, 1'b0, '0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_full: got v=%b r=%b want 1 0", out_valid0, in_ready0);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid0, in_ready0, armed0} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_flush: got %b want 000", {out_valid0, in_ready0, armed0});
    end
    drive(1'b1, 32'h3333, 1'b0, '0, 1'b1); tick();
    drive(1'b0, '0, 1'b1, 32'h7FFF_FFFF, 1'b1); tick();
    got0.delete();
    for (int c = 0; c < 5; c++) begin
      drive(c < 2, 32'h4444 + c, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (out_valid0 && out_ready) got0.push_back(out_data0);
      tick();
    end
    n_checks++;
    if (got0.size() != 2 || got0[0] !== 32'h4444 || got0[1] !== 32'h4445) begin
      n_fail++; $display("FAIL rstmid_resume: got %p want 4444,4445", got0);
    end
  endtask

  task automatic test_random();
    int r;
    logic [31:0] base;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 199);
      rst = (r == 0);
      base = (r % 3 == 0) ? 32'h8000_0000 : ((r % 3 == 1) ? 32'h7FFF_FFFF : $urandom());
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? m_thr + 32'($urandom_range(0, 4)) - 32'd2 : $urandom(),
            r < 8, base, $urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_flags = {m_armed, m_armed && q0.size() < 2, q0.size() > 0,
                   m_armed, m_armed && q1.size() < 2, q1.size() > 0};
      obs_flags = {armed0, in_ready0, out_valid0, armed1, in_ready1, out_valid1};
      n_checks++;
      if (obs_flags !== exp_flags) begin
        n_fail++; $display("FAIL rand_flags c=%0d: got %b want %b", c, obs_flags, exp_flags);
      end
      if (q0.size() > 0) begin
        n_checks++;
        if (out_data0 !== q0[0]) begin
          n_fail++; $display("FAIL rand_data0 c=%0d: got %h want %h", c, out_data0, q0[0]);
        end
      end
      if (q1.size() > 0) begin
        n_checks++;
        if (out_data1 !== q1[0]) begin
          n_fail++; $display("FAIL rand_data1 c=%0d: got %h want %h", c, out_data1, q1[0]);
        end
      end
`ifdef LTEQ_FILT_STATS_EN
      n_checks++;
      if ({pass_cnt0, drop_cnt0, pass_cnt1, drop_cnt1} !==
          {4'(p0), 4'(d0), 4'(p1), 4'(d1)}) begin
        n_fail++;
        $display("FAIL rand_stats c=%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                 pass_cnt0, drop_cnt0, pass_cnt1, drop_cnt1, p0, d0, p1, d1);
      end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef LTEQ_FILT_STATS_EN
  task automatic test_stats();
    drive(1'b0, '0, 1'b1, 32'h7FFF_FFFF, 1'b1);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, $urandom(), 1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (pass_cnt0 !== 4'd15 || drop_cnt0 !== 4'd0 || drop_cnt1 !== 4'd15) begin
      n_fail++;
      $display("FAIL stats_sat: got p0=%0d d0=%0d d1=%0d want 15 0 15",
               pass_cnt0, drop_cnt0, drop_cnt1);
    end
    drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({pass_cnt0, drop_cnt0, pass_cnt1, drop_cnt1} !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_clear: got %0d %0d %0d %0d want 0 0 0 0",
               pass_cnt0, drop_cnt0, pass_cnt1, drop_cnt1);
    end
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_compare();
    test_backpressure();
    test_thr_change();
    test_reset_mid();
`ifdef LTEQ_FILT_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
